lc3_writeback: RTL and testbench

Writeback stage of the LC-3 datapath, directly upstream of the register file write port. Accepts one retiring instruction at a time and selects the result source (ALU, memory load data or PC). For loads it waits on a memory ready handshake. It then drives a single-cycle register write (reg_write_en/DR/write_data) and updates the NZP condition codes.

---
 rtl/lc3_writeback_if.sv | 29 ++
 rtl/lc3_writeback.sv | 146 ++++++++++++++
 tb/tb_lc3_writeback.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3_writeback_if.sv
// lc3_writeback_if: instruction-retire bus feeding the LC-3 writeback stage.
//   master (upstream pipeline / memory side):
//     drives  wb_valid, wb_dr, wb_src, wb_set_cc, alu_result, pc_value,
//             mem_rdata, mem_ready
//     samples wb_ready
//   slave (writeback stage): the mirror image.
interface lc3_writeback_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_dr;
    logic [1:0]  wb_src;
    logic        wb_set_cc;
    logic [15:0] alu_result;
    logic [15:0] pc_value;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output wb_valid, wb_dr, wb_src, wb_set_cc,
        output alu_result, pc_value, mem_rdata, mem_ready,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_dr, wb_src, wb_set_cc,
        input  alu_result, pc_value, mem_rdata, mem_ready,
        output wb_ready
    );
endinterface

// File: rtl/lc3_writeback.sv
// lc3_writeback: LC-3 writeback stage in front of the register file write port.
// Takes one retiring instruction at a time, picks its result (ALU, load data or
// PC link), waits on the memory handshake for loads (with timeout), then issues
// a single-cycle register write and optionally updates the NZP codes.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus (slave)      upstream instruction offer + memory load handshake
//   reg_write_en     register file write strobe (one cycle per write)
//   DR, write_data   register file index / data, held between writes
//   nzp              condition codes {N,Z,P}
//   wb_done          one-cycle pulse per retired instruction (incl. aborted loads)
//   mem_err          one-cycle pulse when a load times out
//   retired_count    retired-instruction counter, wraps
module lc3_writeback #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    lc3_writeback_if.slave   bus,
    output logic             reg_write_en,
    output logic [2:0]       DR,
    output logic [15:0]      write_data,
    output logic [2:0]       nzp,
    output logic             wb_done,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_PC   = 2'b10;
    localparam logic [1:0] SRC_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0]    dr_q;
    logic          cc_q;
    logic          accept;
    logic          write_n, done_n, err_n;
    logic [2:0]    dr_n;
    logic [15:0]   wd_n;

    assign bus.wb_ready = (state == IDLE);
    assign accept       = bus.wb_valid && bus.wb_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_n = state;
        tcnt_n  = tcnt;
        write_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        dr_n    = DR;
        wd_n    = write_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.wb_src)
                        SRC_ALU, SRC_PC: begin
                            wd_n    = (bus.wb_src == SRC_ALU) ? bus.alu_result : bus.pc_value;
                            dr_n    = bus.wb_dr;
                            write_n = 1'b1;
                            done_n  = 1'b1;
                            state_n = WRITE;
                        end
                        SRC_MEM: begin
                            // mem_ready is deliberately not looked at in the accept cycle
                            tcnt_n  = '0;
                            state_n = WAIT_MEM;
                        end
                        default: begin
                            // SRC_NONE: retire immediately, nothing written
                            done_n = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                // data arriving on the last allowed cycle still beats the timeout
                if (bus.mem_ready) begin
                    wd_n    = bus.mem_rdata;
                    dr_n    = dr_q;
                    write_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = WRITE;
                end else if (tcnt == TCNT_LAST) begin
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tcnt          <= '0;
            dr_q          <= 3'd0;
            cc_q          <= 1'b0;
            reg_write_en  <= 1'b0;
            DR            <= 3'd0;
            write_data    <= 16'd0;
            nzp           <= 3'b010;
            wb_done       <= 1'b0;
            mem_err       <= 1'b0;
            retired_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_n;
            tcnt         <= tcnt_n;
            reg_write_en <= write_n;
            DR           <= dr_n;
            write_data   <= wd_n;
            wb_done      <= done_n;
            mem_err      <= err_n;
            if (accept) begin
                dr_q <= bus.wb_dr;
                cc_q <= bus.wb_set_cc;
            end
            if (done_n) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            // write_data already holds the value being written during WRITE
            if (state == WRITE && cc_q) begin
                nzp <= {write_data[15], write_data == 16'd0,
                        !write_data[15] && (write_data != 16'd0)};
            end
        end
    end

endmodule

// File: tb/tb_lc3_writeback.sv
// tb_lc3_writeback: randomized self-checking bench for lc3_writeback.
// A transaction-level model predicts, per instruction, whether a write happens,
// what is written, the resulting NZP and the retired count.
module tb_lc3_writeback;

    localparam int MT = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reg_write_en;
    logic [2:0]    DR;
    logic [15:0]   write_data;
    logic [2:0]    nzp;
    logic          wb_done;
    logic          mem_err;
    logic [CW-1:0] retired_count;

    lc3_writeback_if bus();

    lc3_writeback #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .reg_write_en  (reg_write_en),
        .DR            (DR),
        .write_data    (write_data),
        .nzp           (nzp),
        .wb_done       (wb_done),
        .mem_err       (mem_err),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [2:0]  m_nzp;
    logic [2:0]  m_dr;
    logic [15:0] m_wd;
    int          m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v == 16'd0)        return 3'b010;
        else if (v >= 16'h8000) return 3'b100;
        else                   return 3'b001;
    endfunction

    task automatic model_reset();
        m_nzp   = 3'b010;
        m_dr    = 3'd0;
        m_wd    = 16'd0;
        m_count = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"},    {31'd0, reg_write_en}, 32'd0);
        check({tag, "_done"},  {31'd0, wb_done},      32'd0);
        check({tag, "_err"},   {31'd0, mem_err},      32'd0);
        check({tag, "_ready"}, {31'd0, bus.wb_ready}, 32'd1);
        check({tag, "_nzp"},   {29'd0, nzp},          {29'd0, m_nzp});
        check({tag, "_dr"},    {29'd0, DR},           {29'd0, m_dr});
        check({tag, "_wd"},    {16'd0, write_data},   {16'd0, m_wd});
        check({tag, "_cnt"},   {28'd0, retired_count}, m_count % (1 << CW));
    endtask

    task automatic scramble_inputs();
        bus.wb_dr      = 3'($urandom);
        bus.wb_src     = 2'($urandom);
        bus.wb_set_cc  = 1'($urandom);
        bus.alu_result = 16'($urandom);
        bus.pc_value   = 16'($urandom);
        bus.mem_rdata  = 16'($urandom);
    endtask

    // Issue one instruction and check its whole life. delay = number of
    // WAIT_MEM cycles with mem_ready low before it rises (>= MT means timeout).
    task automatic run_instr(input logic [1:0] src, input logic [2:0] dr, input logic cc,
                             input logic [15:0] val, input int delay, input string tag);
        int  guard;
        bit  writes, aborts;
        guard = 0;
        while (!bus.wb_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.wb_ready) check({tag, "_ready_wait"}, 32'd0, 32'd1);
        scramble_inputs();
        bus.wb_valid  = 1'b1;
        bus.wb_dr     = dr;
        bus.wb_src    = src;
        bus.wb_set_cc = cc;
        if (src == 2'b00) bus.alu_result = val;
        if (src == 2'b10) bus.pc_value   = val;
        bus.mem_ready = 1'($urandom);
        @(negedge clk);
        bus.wb_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        scramble_inputs();
        if (src == 2'b01) begin
            for (int k = 0; k < MT; k++) begin
                check({tag, "_wait_ready"}, {31'd0, bus.wb_ready}, 32'd0);
                check({tag, "_wait_we"},    {31'd0, reg_write_en}, 32'd0);
                check({tag, "_wait_done"},  {31'd0, wb_done},      32'd0);
                bus.mem_ready = (k == delay);
                bus.mem_rdata = (k == delay) ? val : 16'($urandom);
                @(negedge clk);
                bus.mem_ready = 1'b0;
                if (k == delay) break;
            end
        end
        aborts = (src == 2'b01) && (delay >= MT);
        writes = (src != 2'b11) && !aborts;
        check({tag, "_we"},    {31'd0, reg_write_en}, {31'd0, writes});
        check({tag, "_done"},  {31'd0, wb_done},      32'd1);
        check({tag, "_err"},   {31'd0, mem_err},      {31'd0, aborts});
        check({tag, "_ready"}, {31'd0, bus.wb_ready}, {31'd0, !writes});
        check({tag, "_nzp_before"}, {29'd0, nzp},     {29'd0, m_nzp});
        if (writes) begin
            check({tag, "_dr"}, {29'd0, DR},         {29'd0, dr});
            check({tag, "_wd"}, {16'd0, write_data}, {16'd0, val});
            m_dr = dr;
            m_wd = val;
            if (cc) m_nzp = cc_of(val);
        end
        m_count++;
        @(negedge clk);
        check_quiet({tag, "_post"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        scramble_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_quiet("reset");

        // directed cases
        run_instr(2'b00, 3'd3, 1'b1, 16'h8001, 0, "alu");
        run_instr(2'b01, 3'd5, 1'b1, 16'h0000, 3, "load");
        run_instr(2'b10, 3'd7, 1'b0, 16'h3001, 0, "pc_link");
        run_instr(2'b11, 3'd2, 1'b1, 16'h1234, 0, "none");
        run_instr(2'b01, 3'd1, 1'b1, 16'h7fff, MT + 3, "timeout");
        run_instr(2'b01, 3'd4, 1'b1, 16'h0042, MT - 1, "last_cycle");
        run_instr(2'b01, 3'd6, 1'b1, 16'hbeef, 0, "load_fast");

        // reset in the middle of a load
        bus.wb_valid  = 1'b1;
        bus.wb_src    = 2'b01;
        bus.wb_dr     = 3'd6;
        bus.wb_set_cc = 1'b1;
        @(negedge clk);
        bus.wb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_quiet("mid_reset");
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5555;
        repeat (3) begin
            @(negedge clk);
            check_quiet("after_reset");
        end
        bus.mem_ready = 1'b0;

        // counter wrap
        for (int i = 0; i < 17; i++) run_instr(2'b11, 3'($urandom), 1'b1, 16'($urandom), 0, "wrap");
        check("wrap_count", {28'd0, retired_count}, 32'd1);

        // random traffic
        for (int i = 0; i < 150; i++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'h8000 | 16'($urandom);
                default: v = 16'($urandom);
            endcase
            run_instr(2'($urandom), 3'($urandom), 1'($urandom), v,
                      $urandom_range(0, MT + 1), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
